// File: rtl/neighbor_seq_pkg.sv
// Shared types and constants for the neighbour-address memory sequencer.
// Build option: define NEIGHBOR_CLAMP_EN to saturate edge addresses instead of wrapping.
package neighbor_seq_pkg;

  localparam int LANES      = 3;
  localparam int SEQ_DATA_W = 18;

  // Signed address offset of each lane relative to the centre address A.
  localparam int LANE_OFFSET [LANES] = '{-1, 0, 1};

  typedef enum logic [2:0] {
    IDLE,
    ACC0,
    ACC1,
    ACC2,
    DONE
  } seq_state_t;

  typedef logic [LANES-1:0][SEQ_DATA_W-1:0] lane_vec_t;

endpackage

// File: rtl/neighbor_addr_gen.sv
// Combinational lane address generator: centre address plus lane offset.
// Build option: NEIGHBOR_CLAMP_EN saturates at the memory edges and flags the
// clamped lane; otherwise addresses wrap modulo 2^ADDR_W.
module neighbor_addr_gen
  import neighbor_seq_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic [ADDR_W-1:0] centre_addr,
  input  logic [1:0]        lane_idx,
  output logic [ADDR_W-1:0] lane_addr,
  output logic              clamped
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  // Apply the lane offset, then saturate the edge lanes when clamping is built in.
  always_comb begin
    lane_addr = centre_addr;
    clamped   = 1'b0;
    case (lane_idx)
      2'd0:    lane_addr = centre_addr + ADDR_W'(LANE_OFFSET[0]);
      2'd2:    lane_addr = centre_addr + ADDR_W'(LANE_OFFSET[2]);
      default: lane_addr = centre_addr;
    endcase
`ifdef NEIGHBOR_CLAMP_EN
    if ((lane_idx == 2'd0) && (centre_addr == '0)) begin
      lane_addr = '0;
      clamped   = 1'b1;
    end
    if ((lane_idx == 2'd2) && (centre_addr == ADDR_MAX)) begin
      lane_addr = ADDR_MAX;
      clamped   = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/neighbor_mem_sequencer.sv
// Serialises a 3-lane neighbour vector load/store (A-1, A, A+1) onto one
// single-port RAM with 1-cycle read latency, stalling the pipeline meanwhile.
// Build option: NEIGHBOR_CLAMP_EN (edge clamping, handled in neighbor_addr_gen).
module neighbor_mem_sequencer
  import neighbor_seq_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [3*DATA_W-1:0]   req_wdata,
  output logic                  stall,
  output logic [3*DATA_W-1:0]   rdata,
  output logic                  rdata_valid,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  seq_state_t                     state_q, state_d;
  logic                           we_q, we_d;
  logic [ADDR_W-1:0]              addr_q, addr_d;
  logic [LANES-1:0][DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0][DATA_W-1:0]         cap_q, cap_d;
  logic [LANES-1:0][DATA_W-1:0]   rdata_q, rdata_d;

  logic [1:0]                     lane_idx;
  logic [ADDR_W-1:0]              lane_addr;
  logic                           lane_clamped;

  // Which lane the current access state is serving.
  always_comb begin
    case (state_q)
      ACC1:    lane_idx = 2'd1;
      ACC2:    lane_idx = 2'd2;
      default: lane_idx = 2'd0;
    endcase
  end

  neighbor_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .centre_addr (addr_q),
    .lane_idx    (lane_idx),
    .lane_addr   (lane_addr),
    .clamped     (lane_clamped)
  );

  // Next-state, request latching, load capture and RAM port drive.
  // Lanes 0/1 are parked in cap_q so the visible rdata only changes once the
  // whole vector is in; lane 2 is bypassed straight from the RAM in DONE.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cap_d       = cap_q;
    rdata_d     = rdata_q;
    stall       = 1'b0;
    rdata_valid = 1'b0;
    mem_addr    = '0;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    rdata       = rdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          stall   = 1'b1;
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = ACC0;
        end
      end
      ACC0, ACC1, ACC2: begin
        stall    = 1'b1;
        mem_addr = lane_addr;
        mem_we   = we_q & ~lane_clamped;
        if (we_q) begin
          mem_wdata = wdata_q[lane_idx];
        end
        if (!we_q && (state_q == ACC1)) begin
          cap_d[0] = mem_rdata;
        end
        if (!we_q && (state_q == ACC2)) begin
          cap_d[1] = mem_rdata;
        end
        case (state_q)
          ACC0:    state_d = ACC1;
          ACC1:    state_d = ACC2;
          default: state_d = DONE;
        endcase
      end
      DONE: begin
        if (!we_q) begin
          rdata_d     = {mem_rdata, cap_q[1], cap_q[0]};
          rdata       = rdata_d;
          rdata_valid = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cap_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cap_q   <= cap_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_neighbor_mem_sequencer.sv
// Self-checking bench for neighbor_mem_sequencer against a RAM model and a
// reference memory image updated from the neighbour-access rules.
module tb_neighbor_mem_sequencer;
  import neighbor_seq_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 18;
  localparam int DEPTH  = 1 << ADDR_W;

  logic                clk = 1'b0;
  logic                rst;
  logic                req_valid;
  logic                req_we;
  logic [ADDR_W-1:0]   req_addr;
  logic [3*DATA_W-1:0] req_wdata;
  logic                stall;
  logic [3*DATA_W-1:0] rdata;
  logic                rdata_valid;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;

  logic                bd_we;
  logic [ADDR_W-1:0]   bd_addr;
  logic [DATA_W-1:0]   bd_data;

  logic [DATA_W-1:0]   ram     [DEPTH];
  logic [DATA_W-1:0]   ref_mem [DEPTH];
  lane_vec_t           model_rdata;

  int n_checks = 0;
  int n_errors = 0;

  logic                obs_stall [5];
  logic                obs_valid [5];
  logic                obs_we    [5];
  logic [ADDR_W-1:0]   obs_addr  [5];
  logic [DATA_W-1:0]   obs_wd    [5];
  lane_vec_t           obs_rdata [5];

  neighbor_mem_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .stall       (stall),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port RAM with registered read and a backdoor preload port.
  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Lane k touches A-1+k: wrapped, or saturated when clamping is built in.
  function automatic int exp_lane_addr(int a, int k);
    int raw = a + k - 1;
`ifdef NEIGHBOR_CLAMP_EN
    if (raw < 0) return 0;
    if (raw >= DEPTH) return DEPTH - 1;
    return raw;
`else
    return (raw + DEPTH) % DEPTH;
`endif
  endfunction

  // A lane writes unless its address had to be saturated.
  function automatic bit exp_lane_write(int a, int k);
    int raw = a + k - 1;
`ifdef NEIGHBOR_CLAMP_EN
    return (raw >= 0) && (raw < DEPTH);
`else
    return 1'b1;
`endif
  endfunction

  task automatic poke(input int addr, input logic [DATA_W-1:0] data);
    bd_we = 1'b1; bd_addr = ADDR_W'(addr); bd_data = data;
    @(posedge clk); #1;
    bd_we = 1'b0;
    ref_mem[addr] = data;
  endtask

  // Presents one request and records the five cycles of DUT behaviour.
  task automatic run_op(input bit we, input int a, input lane_vec_t wd);
    req_valid = 1'b1; req_we = we; req_addr = ADDR_W'(a); req_wdata = wd;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      obs_stall[c] = stall;     obs_valid[c] = rdata_valid;
      obs_we[c]    = mem_we;    obs_addr[c]  = mem_addr;
      obs_wd[c]    = mem_wdata; obs_rdata[c] = rdata;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks += 6;
    if (stall !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_stall got %b expected 0", stall); end
    if (rdata !== '0) begin n_errors++; $display("[TB] FAIL reset_rdata got %h expected 0", rdata); end
    if (rdata_valid !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_valid got %b expected 0", rdata_valid); end
    if (mem_we !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_mem_we got %b expected 0", mem_we); end
    if (mem_addr !== '0) begin n_errors++; $display("[TB] FAIL reset_mem_addr got %h expected 0", mem_addr); end
    if (mem_wdata !== '0) begin n_errors++; $display("[TB] FAIL reset_mem_wdata got %h expected 0", mem_wdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_load();
    lane_vec_t prev = model_rdata;
    lane_vec_t expv = {18'd7, 18'd6, 18'd5};
    poke(99, 18'd5); poke(100, 18'd6); poke(101, 18'd7);
    run_op(1'b0, 100, '0);
    for (int c = 0; c < 5; c++) begin
      n_checks += 3;
      if (obs_stall[c] !== (c < 4)) begin n_errors++; $display("[TB] FAIL load_stall cycle %0d got %b expected %b", c, obs_stall[c], c < 4); end
      if (obs_valid[c] !== (c == 4)) begin n_errors++; $display("[TB] FAIL load_valid cycle %0d got %b expected %b", c, obs_valid[c], c == 4); end
      if (obs_rdata[c] !== ((c == 4) ? expv : prev)) begin n_errors++; $display("[TB] FAIL load_rdata cycle %0d got %h expected %h", c, obs_rdata[c], (c == 4) ? expv : prev); end
    end
    model_rdata = expv;
  endtask

  task automatic test_store();
    lane_vec_t wd = {18'd3, 18'd2, 18'd1};
    run_op(1'b1, 200, wd);
    for (int c = 0; c < 5; c++) begin
      n_checks += 4;
      if (obs_we[c] !== (c >= 1 && c <= 3)) begin n_errors++; $display("[TB] FAIL store_we cycle %0d got %b", c, obs_we[c]); end
      if (obs_addr[c] !== ((c >= 1 && c <= 3) ? 10'(198 + c) : 10'd0)) begin n_errors++; $display("[TB] FAIL store_addr cycle %0d got %0d", c, obs_addr[c]); end
      if (obs_valid[c] !== 1'b0) begin n_errors++; $display("[TB] FAIL store_valid cycle %0d got %b expected 0", c, obs_valid[c]); end
      if (obs_rdata[c] !== model_rdata) begin n_errors++; $display("[TB] FAIL store_rdata cycle %0d got %h expected %h", c, obs_rdata[c], model_rdata); end
    end
    for (int k = 0; k < 3; k++) begin
      ref_mem[199 + k] = wd[k];
      n_checks++;
      if (ram[199 + k] !== 18'(k + 1)) begin n_errors++; $display("[TB] FAIL store_ram addr %0d got %0d expected %0d", 199 + k, ram[199 + k], k + 1); end
    end
  endtask

  task automatic test_edges();
    poke(1023, 18'd9); poke(0, 18'd44); poke(1, 18'd45); poke(1022, 18'd46);
    run_op(1'b0, 0, '0);
    n_checks += 2;
`ifdef NEIGHBOR_CLAMP_EN
    if (obs_rdata[4][0] !== 18'd44) begin n_errors++; $display("[TB] FAIL edge_low_lane0 got %0d expected 44", obs_rdata[4][0]); end
`else
    if (obs_rdata[4][0] !== 18'd9) begin n_errors++; $display("[TB] FAIL edge_low_lane0 got %0d expected 9", obs_rdata[4][0]); end
`endif
    if (obs_addr[1] !== 10'(exp_lane_addr(0, 0))) begin n_errors++; $display("[TB] FAIL edge_low_addr got %0d expected %0d", obs_addr[1], exp_lane_addr(0, 0)); end
    model_rdata = obs_rdata[4];
    run_op(1'b0, 1023, '0);
    n_checks += 1;
`ifdef NEIGHBOR_CLAMP_EN
    if (obs_rdata[4] !== {18'd9, 18'd9, 18'd46}) begin n_errors++; $display("[TB] FAIL edge_high got %h", obs_rdata[4]); end
`else
    if (obs_rdata[4] !== {18'd44, 18'd9, 18'd46}) begin n_errors++; $display("[TB] FAIL edge_high got %h", obs_rdata[4]); end
`endif
    model_rdata = obs_rdata[4];
  endtask

  task automatic test_back_to_back();
    logic s_all [10];
    lane_vec_t r1, r2;
    for (int k = 0; k < 3; k++) begin r1[k] = ref_mem[9 + k]; r2[k] = ref_mem[19 + k]; end
    run_op(1'b0, 10, '0);
    for (int c = 0; c < 5; c++) s_all[c] = obs_stall[c];
    n_checks++;
    if (obs_rdata[4] !== r1) begin n_errors++; $display("[TB] FAIL b2b_first_rdata got %h expected %h", obs_rdata[4], r1); end
    run_op(1'b0, 20, '0);
    for (int c = 0; c < 5; c++) s_all[c + 5] = obs_stall[c];
    n_checks++;
    if (obs_rdata[4] !== r2) begin n_errors++; $display("[TB] FAIL b2b_second_rdata got %h expected %h", obs_rdata[4], r2); end
    for (int c = 0; c < 10; c++) begin
      n_checks++;
      if (s_all[c] !== !(c == 4 || c == 9)) begin n_errors++; $display("[TB] FAIL b2b_stall cycle %0d got %b expected %b", c, s_all[c], !(c == 4 || c == 9)); end
    end
    model_rdata = r2;
  endtask

  task automatic test_reset_mid_store();
    poke(49, 18'd100); poke(50, 18'd101); poke(51, 18'd102);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 10'd50; req_wdata = {18'd33, 18'd22, 18'd11};
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks += 5;
    if (stall !== 1'b0) begin n_errors++; $display("[TB] FAIL rst_mid_stall got %b expected 0", stall); end
    if (rdata !== '0) begin n_errors++; $display("[TB] FAIL rst_mid_rdata got %h expected 0", rdata); end
    if (rdata_valid !== 1'b0) begin n_errors++; $display("[TB] FAIL rst_mid_valid got %b expected 0", rdata_valid); end
    if (mem_we !== 1'b0) begin n_errors++; $display("[TB] FAIL rst_mid_we got %b expected 0", mem_we); end
    if (mem_addr !== '0) begin n_errors++; $display("[TB] FAIL rst_mid_addr got %h expected 0", mem_addr); end
    repeat (3) @(posedge clk);
    #1;
    n_checks += 3;
    if (ram[49] !== 18'd11) begin n_errors++; $display("[TB] FAIL rst_mid_ram49 got %0d expected 11", ram[49]); end
    if (ram[50] !== 18'd101) begin n_errors++; $display("[TB] FAIL rst_mid_ram50 got %0d expected 101", ram[50]); end
    if (ram[51] !== 18'd102) begin n_errors++; $display("[TB] FAIL rst_mid_ram51 got %0d expected 102", ram[51]); end
    ref_mem[49] = 18'd11;
    model_rdata = '0;
  endtask

  task automatic test_idle();
    req_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      req_we = 1'($urandom_range(0, 1)); req_addr = ADDR_W'($urandom);
      @(negedge clk);
      n_checks++;
      if (stall !== 1'b0 || mem_we !== 1'b0) begin n_errors++; $display("[TB] FAIL idle cycle %0d got stall=%b we=%b expected 0/0", c, stall, mem_we); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      bit        we = 1'($urandom_range(0, 1));
      int        a;
      lane_vec_t wd, prev, expv;
      int        ea [3];
      bit        ew [3];
      case ($urandom_range(0, 4))
        0:       a = 0;
        1:       a = DEPTH - 1;
        default: a = int'($urandom_range(0, DEPTH - 1));
      endcase
      for (int k = 0; k < 3; k++) begin
        wd[k] = DATA_W'($urandom);
        ea[k] = exp_lane_addr(a, k);
        ew[k] = we && exp_lane_write(a, k);
        expv[k] = ref_mem[ea[k]];
      end
      prev = model_rdata;
      run_op(we, a, wd);
      for (int c = 0; c < 5; c++) begin
        bit acc = (c >= 1 && c <= 3);
        n_checks += 5;
        if (obs_stall[c] !== (c < 4)) begin n_errors++; $display("[TB] FAIL rnd_stall op %0d cycle %0d got %b", n, c, obs_stall[c]); end
        if (obs_valid[c] !== (c == 4 && !we)) begin n_errors++; $display("[TB] FAIL rnd_valid op %0d cycle %0d got %b", n, c, obs_valid[c]); end
        if (obs_we[c] !== (acc ? ew[acc ? c - 1 : 0] : 1'b0)) begin n_errors++; $display("[TB] FAIL rnd_we op %0d cycle %0d got %b", n, c, obs_we[c]); end
        if (obs_addr[c] !== (acc ? 10'(ea[acc ? c - 1 : 0]) : 10'd0)) begin n_errors++; $display("[TB] FAIL rnd_addr op %0d cycle %0d got %0d", n, c, obs_addr[c]); end
        if (obs_rdata[c] !== ((c == 4 && !we) ? expv : prev)) begin n_errors++; $display("[TB] FAIL rnd_rdata op %0d cycle %0d got %h expected %h", n, c, obs_rdata[c], (c == 4 && !we) ? expv : prev); end
        if (we && acc && ew[c - 1]) begin
          n_checks++;
          if (obs_wd[c] !== wd[c - 1]) begin n_errors++; $display("[TB] FAIL rnd_wdata op %0d cycle %0d got %h expected %h", n, c, obs_wd[c], wd[c - 1]); end
        end
      end
      if (we) begin
        for (int k = 0; k < 3; k++) if (ew[k]) ref_mem[ea[k]] = wd[k];
        for (int k = 0; k < 3; k++) begin
          n_checks++;
          if (ram[ea[k]] !== ref_mem[ea[k]]) begin n_errors++; $display("[TB] FAIL rnd_ram op %0d addr %0d got %h expected %h", n, ea[k], ram[ea[k]], ref_mem[ea[k]]); end
        end
      end else begin
        model_rdata = expv;
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    model_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    for (int i = 0; i < DEPTH; i++) poke(i, DATA_W'($urandom));
    test_load();
    test_store();
    test_edges();
    test_back_to_back();
    test_reset_mid_store();
    test_idle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
